sdm_dac: RTL

First-order sigma-delta DAC. It is the output-direction counterpart of the ramp/TDC ADC path: it converts a stream of unsigned samples into a 1-bit density-modulated pin signal, which an external RC filter turns into an analog level. Samples arrive over a valid/ready handshake into a small FIFO. Each sample is modulated for exactly OSR clocks.

---
 rtl/sdm_dac.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sdm_dac.sv
// rtl/sdm_dac.sv - first-order sigma-delta DAC with a small sample FIFO
// Each sample drives the modulator for OSR clocks; the accumulator residue carries across samples.
module sdm_dac #(
  parameter int DATA_BITS  = 8,
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [DATA_BITS-1:0]              sample_in,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  input  logic                              enable,
  input  logic                              underrun_clr,
  output logic                              dac_out,
  output logic                              sample_strobe,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(OSR);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr;
  logic [PW:0]          rd_ptr;
  logic                 ready_en;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS:0]   acc;
  logic [CW-1:0]        counter;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 at_boundary;
  logic                 underrun_set;
  logic [DATA_BITS:0]   sum;
  logic [DATA_BITS-1:0] head;

  assign fifo_level   = LW'(wr_ptr - rd_ptr);
  assign full         = (fifo_level == LW'(FIFO_DEPTH));
  assign empty        = (fifo_level == '0);
  // ready_en keeps sample_ready low while reset is held and rises on the first clock after release
  assign sample_ready = ready_en && !full;
  assign push         = sample_valid && sample_ready;
  assign head         = mem[rd_ptr[PW-1:0]];
  assign at_boundary  = (counter == CW'(OSR - 1));
  assign pop          = enable && !empty && ((state == IDLE) || at_boundary);
  assign underrun_set = (state == RUN) && enable && at_boundary && empty;
  assign sum          = {1'b0, acc[DATA_BITS-1:0]} + {1'b0, hold};

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= sample_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      hold          <= '0;
      acc           <= '0;
      counter       <= '0;
      dac_out       <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      case (state)
        IDLE: begin
          dac_out <= 1'b0;
          acc     <= '0;
          if (pop) begin
            hold          <= head;
            counter       <= '0;
            sample_strobe <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            acc     <= '0;
            dac_out <= 1'b0;
            counter <= '0;
          end else begin
            dac_out <= sum[DATA_BITS];
            acc     <= sum;
            if (at_boundary) begin
              counter <= '0;
              // an empty FIFO leaves hold untouched so the last sample repeats
              if (pop) begin
                hold          <= head;
                sample_strobe <= 1'b1;
              end
            end else begin
              counter <= counter + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

endmodule
